fb_port_arbiter: RTL and testbench

Shares the single-port frame-buffer BRAM among three requesters: the camera pixel writer, the VGA scan-out reader, and an auxiliary host port used for overlay writes and pixel readback. Camera writes are buffered in a small FIFO so that VGA reads can pre-empt them without losing pixels. A frame-aligned freeze controller lets the picture be held on a still frame. The block sits between camera_get_pic / vga_display2 and the frame-buffer memory, replacing their direct dual-port connection.

---
 rtl/fb_pkg.sv | 7 +
 rtl/fb_port_arbiter_if.sv | 42 ++++
 rtl/fb_wr_fifo.sv | 40 ++++
 rtl/fb_port_arbiter.sv | 87 ++++++++
 tb/tb_fb_port_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer widths, read-return source tags and freeze-controller states
package fb_pkg;
  localparam int FB_AW = 19;
  localparam int FB_DW = 12;
  typedef enum logic [1:0] {SRC_NONE, SRC_VGA, SRC_AUX} src_t;
  typedef enum logic [1:0] {LIVE, FREEZE_PEND, FROZEN, RESUME_PEND} frz_t;
endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: requester and BRAM signals of the frame-buffer arbiter
//   slave  : arbiter side (camera/vga/aux/freeze/mem_dout in; grants, read returns, mem_* out)
//   master : requester and memory side (mirror of slave)
interface fb_port_arbiter_if;
  import fb_pkg::*;
  logic             cam_we;
  logic [FB_AW-1:0] cam_addr;
  logic [FB_DW-1:0] cam_data;
  logic             cam_frame_start;
  logic             freeze_req;
  logic             frozen;
  logic             vga_re;
  logic [FB_AW-1:0] vga_addr;
  logic [FB_DW-1:0] vga_data;
  logic             vga_valid;
  logic             aux_req;
  logic             aux_we;
  logic [FB_AW-1:0] aux_addr;
  logic [FB_DW-1:0] aux_wdata;
  logic             aux_gnt;
  logic [FB_DW-1:0] aux_rdata;
  logic             aux_rvalid;
  logic             cam_ovf;
  logic             cam_ovf_clr;
  logic             mem_en;
  logic             mem_we;
  logic [FB_AW-1:0] mem_addr;
  logic [FB_DW-1:0] mem_din;
  logic [FB_DW-1:0] mem_dout;
  modport slave (
    input  cam_we, cam_addr, cam_data, cam_frame_start, freeze_req, vga_re, vga_addr,
           aux_req, aux_we, aux_addr, aux_wdata, cam_ovf_clr, mem_dout,
    output frozen, vga_data, vga_valid, aux_gnt, aux_rdata, aux_rvalid, cam_ovf,
           mem_en, mem_we, mem_addr, mem_din
  );
  modport master (
    output cam_we, cam_addr, cam_data, cam_frame_start, freeze_req, vga_re, vga_addr,
           aux_req, aux_we, aux_addr, aux_wdata, cam_ovf_clr, mem_dout,
    input  frozen, vga_data, vga_valid, aux_gnt, aux_rdata, aux_rvalid, cam_ovf,
           mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous camera write FIFO with occupancy count
//   clk, rst (sync, active-low); push/din write; pop advances head; dout = head; count = occupancy
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  buf_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // a push into a full FIFO lands in the slot the simultaneous pop just vacated
  always_ff @(posedge clk) if (push) buf_q[wr_q] <= din;
  assign dout = buf_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: single-port frame-buffer BRAM arbiter for camera writes, VGA reads and aux host
//   clk, rst (sync, active-low); bus.slave carries camera/freeze, VGA, aux and mem_* signals
//   one registered access per cycle: VGA > urgent camera pop > aux > camera pop
module fb_port_arbiter import fb_pkg::*; #(
  parameter int MEM_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  fb_port_arbiter_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = FB_AW + FB_DW;
  frz_t st_q, st_d;
  src_t tag_q [MEM_LAT+1];
  src_t tag_d [MEM_LAT+1];
  logic [CW-1:0] cnt;
  logic [EW-1:0] head;
  logic urgent, pop, push, drop, discard, gnt;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, cam_ovf_q, cam_ovf_d;
  logic [FB_AW-1:0] mem_addr_q, mem_addr_d;
  logic [FB_DW-1:0] mem_din_q, mem_din_d;
  fb_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({bus.cam_addr, bus.cam_data}),
    .dout(head),
    .count(cnt)
  );
  always_comb begin
    urgent = cnt >= CW'(FIFO_DEPTH - 1);
    pop = !bus.vga_re && cnt != '0 && (urgent || !bus.aux_req);
    gnt = !bus.vga_re && !urgent && bus.aux_req;
    // the frame-start pulse itself is the first discarded (freezing) or first kept (resuming) pixel
    discard = st_q == FROZEN || (st_q == RESUME_PEND && !bus.cam_frame_start) ||
              (st_q == FREEZE_PEND && bus.cam_frame_start);
    push = bus.cam_we && !discard && (cnt != CW'(FIFO_DEPTH) || pop);
    drop = bus.cam_we && !discard && cnt == CW'(FIFO_DEPTH) && !pop;
    cam_ovf_d = drop || (cam_ovf_q && !bus.cam_ovf_clr);
    mem_en_d = bus.vga_re || pop || gnt;
    mem_we_d = pop || (gnt && bus.aux_we);
    mem_addr_d = bus.vga_re ? bus.vga_addr : pop ? head[EW-1:FB_DW] : gnt ? bus.aux_addr : '0;
    mem_din_d = pop ? head[FB_DW-1:0] : (gnt && bus.aux_we) ? bus.aux_wdata : '0;
    tag_d[0] = bus.vga_re ? SRC_VGA : (gnt && !bus.aux_we) ? SRC_AUX : SRC_NONE;
    for (int i = 1; i <= MEM_LAT; i++) tag_d[i] = tag_q[i-1];
    st_d = st_q;
    case (st_q)
      LIVE:        st_d = bus.freeze_req ? FREEZE_PEND : LIVE;
      FREEZE_PEND: st_d = bus.cam_frame_start ? FROZEN : bus.freeze_req ? FREEZE_PEND : LIVE;
      FROZEN:      st_d = bus.freeze_req ? FROZEN : RESUME_PEND;
      RESUME_PEND: st_d = bus.cam_frame_start ? LIVE : bus.freeze_req ? FROZEN : RESUME_PEND;
      default:     st_d = LIVE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= LIVE;
      tag_q <= '{default: SRC_NONE};
      cam_ovf_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
    end else begin
      st_q <= st_d;
      tag_q <= tag_d;
      cam_ovf_q <= cam_ovf_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
    end
  end
  assign bus.frozen = st_q == FROZEN || st_q == RESUME_PEND;
  assign bus.aux_gnt = gnt && rst;
  assign bus.vga_valid = tag_q[MEM_LAT] == SRC_VGA;
  assign bus.aux_rvalid = tag_q[MEM_LAT] == SRC_AUX;
  assign bus.vga_data = bus.vga_valid ? bus.mem_dout : '0;
  assign bus.aux_rdata = bus.aux_rvalid ? bus.mem_dout : '0;
  assign bus.cam_ovf = cam_ovf_q;
  assign bus.mem_en = mem_en_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din = mem_din_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: scoreboard bench running MEM_LAT=1 and MEM_LAT=2 arbiters on identical stimulus
module tb_fb_port_arbiter;
  localparam int D = 4;
  localparam int BIG = 32'h7fff_ffff;
  localparam int M_LIVE = 0, M_PEND = 1, M_FROZ = 2, M_RES = 3;
  typedef struct {
    bit          aux;
    logic [11:0] data;
    int          issue;
    int          kill;
  } rd_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic        cam_we, cam_frame_start, freeze_req, vga_re, aux_req, aux_we, cam_ovf_clr;
  logic [18:0] cam_addr, vga_addr, aux_addr;
  logic [11:0] cam_data, aux_wdata;
  logic [11:0] ref_m [0:(1<<19)-1];
  rd_t         rd_list [$];
  logic [18:0] cam_touch [$];
  int m_st, m_occ;
  bit m_ovf, last_gnt;
  logic [1:0]  o_gnt, o_frz, o_ovf;
  logic [61:0] o_all [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] init_val(input int i);
    return 12'((i * 37) ^ (i >> 5));
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = g + 1;
    fb_port_arbiter_if b();
    fb_port_arbiter #(.MEM_LAT(LAT), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(b.slave));
    assign b.cam_we = cam_we;
    assign b.cam_addr = cam_addr;
    assign b.cam_data = cam_data;
    assign b.cam_frame_start = cam_frame_start;
    assign b.freeze_req = freeze_req;
    assign b.vga_re = vga_re;
    assign b.vga_addr = vga_addr;
    assign b.aux_req = aux_req;
    assign b.aux_we = aux_we;
    assign b.aux_addr = aux_addr;
    assign b.aux_wdata = aux_wdata;
    assign b.cam_ovf_clr = cam_ovf_clr;
    assign o_gnt[g] = b.aux_gnt;
    assign o_frz[g] = b.frozen;
    assign o_ovf[g] = b.cam_ovf;
    assign o_all[g] = {b.frozen, b.vga_valid, b.aux_rvalid, b.aux_gnt, b.cam_ovf, b.mem_en,
                       b.mem_we, b.mem_addr, b.mem_din, b.vga_data, b.aux_rdata};
    logic [11:0] fbm [0:(1<<19)-1];
    logic [11:0] rp [LAT];
    int idx = 0;
    initial for (int i = 0; i < (1 << 19); i++) fbm[i] = init_val(i);
    always @(posedge clk) begin
      if (b.mem_en) begin
        if (b.mem_we) fbm[b.mem_addr] <= b.mem_din;
        rp[0] <= fbm[b.mem_addr];
      end
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign b.mem_dout = rp[LAT-1];
    always @(negedge clk) begin
      if (b.vga_valid || b.aux_rvalid) begin
        while (idx < rd_list.size() && rd_list[idx].issue + 1 + LAT > rd_list[idx].kill) idx++;
        if (idx >= rd_list.size()) chk($sformatf("L%0d spurious_valid", LAT), 1, 0);
        else begin
          chk($sformatf("L%0d single_valid", LAT), b.vga_valid && b.aux_rvalid, 0);
          chk($sformatf("L%0d source", LAT), b.aux_rvalid, rd_list[idx].aux);
          chk($sformatf("L%0d read_data", LAT), rd_list[idx].aux ? b.aux_rdata : b.vga_data,
              rd_list[idx].data);
          chk($sformatf("L%0d latency", LAT), cyc, rd_list[idx].issue + 1 + LAT);
          idx++;
        end
      end
    end
  end

  task automatic idle();
    cam_we = 0; cam_addr = '0; cam_data = '0; cam_frame_start = 0; freeze_req = 0;
    vga_re = 0; vga_addr = '0; aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
    cam_ovf_clr = 0;
  endtask

  // one clock of the behavioural model: decides grants, FIFO acceptance and freeze state
  task automatic cycle();
    bit urg, pop, gnt, disc, acc, drp;
    #1;
    urg = m_occ >= D - 1;
    pop = !vga_re && m_occ > 0 && (urg || !aux_req);
    gnt = !vga_re && !urg && aux_req;
    disc = m_st == M_FROZ || (m_st == M_RES && !cam_frame_start) || (m_st == M_PEND && cam_frame_start);
    acc = cam_we && !disc && (m_occ < D || pop);
    drp = cam_we && !disc && !acc;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d aux_gnt", g + 1), o_gnt[g], gnt);
      chk($sformatf("L%0d frozen", g + 1), o_frz[g], m_st == M_FROZ || m_st == M_RES);
      chk($sformatf("L%0d cam_ovf", g + 1), o_ovf[g], m_ovf);
    end
    if (vga_re) rd_list.push_back('{1'b0, ref_m[vga_addr], cyc, BIG});
    else if (gnt) begin
      if (aux_we) ref_m[aux_addr] = aux_wdata;
      else rd_list.push_back('{1'b1, ref_m[aux_addr], cyc, BIG});
    end
    if (cam_we) cam_touch.push_back(cam_addr);
    if (acc) ref_m[cam_addr] = cam_data;
    m_occ = m_occ + int'(acc) - int'(pop);
    m_ovf = drp || (m_ovf && !cam_ovf_clr);
    case (m_st)
      M_LIVE:  m_st = freeze_req ? M_PEND : M_LIVE;
      M_PEND:  m_st = cam_frame_start ? M_FROZ : freeze_req ? M_PEND : M_LIVE;
      M_FROZ:  m_st = freeze_req ? M_FROZ : M_RES;
      default: m_st = cam_frame_start ? M_LIVE : freeze_req ? M_FROZ : M_RES;
    endcase
    last_gnt = gnt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    #1;
    foreach (rd_list[i]) if (rd_list[i].kill > cyc) rd_list[i].kill = cyc;
    @(negedge clk);
    rst = 1;
    m_st = M_LIVE; m_occ = 0; m_ovf = 0; last_gnt = 0;
    #1;
    for (int g = 0; g < 2; g++) chk($sformatf("L%0d reset_outputs", g + 1), o_all[g], 0);
    @(negedge clk);
  endtask

  task automatic aux_op(input bit we, input logic [18:0] a, input logic [11:0] d);
    aux_req = 1; aux_we = we; aux_addr = a; aux_wdata = d;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_gnt) break;
    end
    idle();
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) cycle();
  endtask

  task automatic pending(input int i0, input int lat);
    int i = i0;
    while (i < rd_list.size() && rd_list[i].issue + 1 + lat > rd_list[i].kill) i++;
    chk($sformatf("L%0d reads_outstanding", lat), i, rd_list.size());
  endtask

  initial begin
    idle();
    m_st = M_LIVE; m_occ = 0; m_ovf = 0; last_gnt = 0;
    for (int i = 0; i < (1 << 19); i++) ref_m[i] = init_val(i);
    repeat (2) @(negedge clk);
    do_reset();
    // aux write then read-back of the same word, VGA idle
    drain(2);
    aux_op(1, 19'h12345, 12'hABC);
    aux_op(0, 19'h12345, 12'h000);
    drain(4);
    // scan line: VGA leaves a slot every third cycle, camera writes every fourth
    for (int c = 0; c < 640; c++) begin
      vga_re = (c % 3) != 2; vga_addr = 19'(c);
      cam_we = (c % 4) == 0; cam_addr = 19'h40000 + 19'(c); cam_data = 12'(c * 5 + 1);
      cycle();
    end
    drain(8);
    // overflow: VGA hogs 20 cycles while camera writes every cycle
    for (int c = 0; c < 20; c++) begin
      vga_re = 1; vga_addr = 19'h300 + 19'(c);
      cam_we = 1; cam_addr = 19'h40400 + 19'(c); cam_data = 12'hF00 + 12'(c);
      cycle();
    end
    drain(6);
    cam_ovf_clr = 1;
    cycle();
    drain(3);
    // freeze and resume around two frame-start pulses, camera writing every cycle
    for (int c = 0; c < 40; c++) begin
      cam_we = 1; cam_addr = 19'h41000 + 19'(c); cam_data = 12'h500 + 12'(c);
      freeze_req = c >= 5 && c < 25;
      cam_frame_start = c == 15 || c == 32;
      if (c == 20) begin aux_req = 1; aux_we = 1; aux_addr = 19'h0100; aux_wdata = 12'h3C3; end
      cycle();
      if (last_gnt) aux_req = 0;
    end
    drain(4);
    vga_re = 1; vga_addr = 19'h0100;
    cycle();
    // freeze request withdrawn before any frame start
    for (int c = 0; c < 8; c++) begin
      vga_re = 0;
      cam_we = 1; cam_addr = 19'h42000 + 19'(c); cam_data = 12'h700 + 12'(c);
      freeze_req = c >= 2 && c < 5;
      cycle();
    end
    drain(6);
    // reset one cycle after a VGA read issues
    vga_re = 1; vga_addr = 19'h0777;
    cycle();
    do_reset();
    drain(6);
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      vga_re = $urandom_range(0, 9) < 6; vga_addr = 19'($urandom_range(0, 'h3FF));
      cam_we = $urandom_range(0, 1); cam_addr = 19'h40000 + 19'($urandom_range(0, 255));
      cam_data = 12'($urandom);
      cam_frame_start = $urandom_range(0, 29) == 0;
      cam_ovf_clr = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 49) == 0) freeze_req = !freeze_req;
      if (!aux_req && $urandom_range(0, 9) < 3) begin
        aux_req = 1; aux_we = $urandom_range(0, 1);
        aux_addr = 19'($urandom_range(0, 'h3FF)); aux_wdata = 12'($urandom);
      end
      cycle();
      if (last_gnt) aux_req = 0;
    end
    drain(30);
    foreach (cam_touch[i]) begin
      chk("L1 cam_mem", g_dut[0].fbm[cam_touch[i]], ref_m[cam_touch[i]]);
      chk("L2 cam_mem", g_dut[1].fbm[cam_touch[i]], ref_m[cam_touch[i]]);
    end
    chk("L1 aux_overlay_mem", g_dut[0].fbm[19'h0100], ref_m[19'h0100]);
    pending(g_dut[0].idx, 1);
    pending(g_dut[1].idx, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
